// File: rtl/fetch_unit_pkg.sv
// Shared core constants for the fetch slice.
// Bus widths used by the front end and the instruction ROM.
package fetch_unit_pkg;

    localparam int CORE_XLEN      = 32;
    localparam int CORE_ROM_AW    = 10;
    localparam int CORE_DBUS_AW   = 12;
    localparam int CORE_INST_BYTES = CORE_XLEN / 8;

    typedef enum logic [1:0] {
        FETCH_OK     = 2'b00,
        FETCH_FAULT  = 2'b01
    } fetch_status_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: ROM word addressing, range check and
// capture of the last faulting pc.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int WIDTH          = CORE_XLEN,
    parameter int ROM_ADDR_WIDTH = CORE_ROM_AW
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          pc,
    output logic                      ibus_rd_en,
    output logic [ROM_ADDR_WIDTH-1:0] ibus_rd_addr,
    input  logic [WIDTH-1:0]          ibus_rd_data,
    output logic [WIDTH-1:0]          inst,
    output logic                      access_fault,
    output logic [WIDTH-1:0]          fault_pc,
    output logic                      fault_seen
);

    logic [WIDTH-1:0] fault_pc_q;
    logic [WIDTH-1:0] fault_pc_d;
    logic             fault_seen_q;
    logic             fault_seen_d;

    // Byte offset bits are checked elsewhere; kept only to mark them intentionally idle.
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^pc[1:0];

    // Combinational address, data and range check.
    always_comb begin
        ibus_rd_addr = pc[ROM_ADDR_WIDTH+1:2];
        inst         = ibus_rd_data;
        access_fault = |pc[WIDTH-1:ROM_ADDR_WIDTH+2];
        ibus_rd_en   = ~rst;
    end

    // Next-state: load pc and set sticky flag on a fault, else hold.
    always_comb begin
        fault_pc_d   = fault_pc_q;
        fault_seen_d = fault_seen_q;
        if (access_fault) begin
            fault_pc_d   = pc;
            fault_seen_d = 1'b1;
        end
    end

    // Fault capture registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_pc_q   <= '0;
            fault_seen_q <= 1'b0;
        end else begin
            fault_pc_q   <= fault_pc_d;
            fault_seen_q <= fault_seen_d;
        end
    end

    assign fault_pc   = fault_pc_q;
    assign fault_seen = fault_seen_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus random checks of fetch_unit against a
// behavioural model of the fetch rules.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        ibus_rd_en;
    logic [9:0]  ibus_rd_addr;
    logic [31:0] ibus_rd_data;
    logic [31:0] inst;
    logic        access_fault;
    logic [31:0] fault_pc;
    logic        fault_seen;

    int vectors;
    int miscompares;

    logic [31:0] m_fpc;
    logic        m_seen;

    fetch_unit #(.WIDTH(32), .ROM_ADDR_WIDTH(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .ibus_rd_en   (ibus_rd_en),
        .ibus_rd_addr (ibus_rd_addr),
        .ibus_rd_data (ibus_rd_data),
        .inst         (inst),
        .access_fault (access_fault),
        .fault_pc     (fault_pc),
        .fault_seen   (fault_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected combinational outputs derived from address arithmetic.
    task automatic check_comb(input string tag);
        check({tag, ".addr"}, 32'(ibus_rd_addr), (pc / 4) % 1024);
        check({tag, ".inst"}, inst, ibus_rd_data);
        check({tag, ".fault"}, 32'(access_fault), 32'(pc >= 32'h1000));
    endtask

    // Clock edge: model capture, then check the registers after it.
    task automatic tick(input string tag);
        @(posedge clk);
        if (!rst && pc >= 32'h1000) begin
            m_fpc  = pc;
            m_seen = 1'b1;
        end
        #1;
        check({tag, ".fpc"}, fault_pc, m_fpc);
        check({tag, ".seen"}, 32'(fault_seen), 32'(m_seen));
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_fpc       = '0;
        m_seen      = 1'b0;
        rst          = 1'b1;
        pc           = 32'h0;
        ibus_rd_data = 32'h0;
        #1;
        check("rst.fpc", fault_pc, 32'h0);
        check("rst.seen", 32'(fault_seen), 32'h0);
        check("rst.en", 32'(ibus_rd_en), 32'h0);

        @(negedge clk);
        pc           = 32'h0000_1000;
        ibus_rd_data = 32'h1234_5678;
        #1;
        check_comb("rst_comb");
        tick("rst_hold");

        pc  = 32'h0;
        rst = 1'b0;
        #1;
        check("rel.en", 32'(ibus_rd_en), 32'h1);

        pc           = 32'h0000_0ABC;
        ibus_rd_data = ~pc;
        #1;
        check("r27.addr", 32'(ibus_rd_addr), 32'h2AF);
        check("r27.inst", inst, 32'hFFFF_F543);
        check("r27.fault", 32'(access_fault), 32'h0);
        tick("r27");

        pc           = 32'h0000_1000;
        ibus_rd_data = ~pc;
        #1;
        check("r28.fault", 32'(access_fault), 32'h1);
        tick("r28");
        check("r28.fpc_k", fault_pc, 32'h0000_1000);
        check("r28.seen_k", 32'(fault_seen), 32'h1);

        pc = 32'h8000_0000;
        ibus_rd_data = ~pc;
        tick("r30a");
        pc = 32'h0000_0004;
        ibus_rd_data = ~pc;
        #1;
        check_comb("r30b");
        tick("r30b");
        check("r30.fpc_k", fault_pc, 32'h8000_0000);
        check("r30.seen_k", 32'(fault_seen), 32'h1);

        for (int i = 0; i < 128; i++) begin
            logic [31:0] p;
            p = 32'($urandom_range(0, 1023)) << 2;
            p = p | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                p = p | ($urandom & 32'hFFFF_F000);
            pc           = p;
            ibus_rd_data = ~p;
            #1;
            check_comb("rnd");
            check("rnd.inv", inst, ~pc);
            tick("rnd");
        end

        pc = 32'hDEAD_0000;
        ibus_rd_data = ~pc;
        tick("r31a");
        #2;
        rst = 1'b1;
        m_fpc  = '0;
        m_seen = 1'b0;
        #1;
        check("r31.fpc", fault_pc, 32'h0);
        check("r31.seen", 32'(fault_seen), 32'h0);
        check("r31.en", 32'(ibus_rd_en), 32'h0);
        check_comb("r31_comb");
        @(negedge clk);
        pc  = 32'h0000_0010;
        ibus_rd_data = ~pc;
        rst = 1'b0;
        #1;
        check("r31.en_rel", 32'(ibus_rd_en), 32'h1);
        tick("r31b");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data and address width in bits.
REQ-002 The block SHALL have parameter ROM_ADDR_WIDTH, default 10, meaning the instruction ROM word-address width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port pc, input, WIDTH bits: byte address of the instruction to fetch.
REQ-006 The block SHALL have port ibus_rd_en, output, 1 bit: instruction-bus read enable.
REQ-007 The block SHALL have port ibus_rd_addr, output, ROM_ADDR_WIDTH bits: ROM word address.
REQ-008 The block SHALL have port ibus_rd_data, input, WIDTH bits: ROM read data.
REQ-009 The block SHALL have port inst, output, WIDTH bits: fetched instruction.
REQ-010 The block SHALL have port access_fault, output, 1 bit: pc lies outside the ROM range.
REQ-011 The block SHALL have port fault_pc, output, WIDTH bits: pc captured at the most recent access fault.
REQ-012 The block SHALL have port fault_seen, output, 1 bit: sticky flag, set once any access fault has occurred since reset.

Function
REQ-013 ibus_rd_addr SHALL equal pc[ROM_ADDR_WIDTH+1:2], combinationally, with zero latency.
REQ-014 pc[1:0] SHALL be ignored by this block; alignment checking belongs to other logic.
REQ-015 inst SHALL equal ibus_rd_data combinationally, with no register, whether or not access_fault is set.
REQ-016 access_fault SHALL be the OR-reduction of pc[WIDTH-1:ROM_ADDR_WIDTH+2], combinationally.
REQ-017 ibus_rd_en SHALL be 1 whenever rst is low and 0 while rst is high; it SHALL NOT depend on access_fault.
REQ-018 On a rising clk edge with access_fault=1, fault_pc SHALL load pc and fault_seen SHALL become 1.
REQ-019 On a rising clk edge with access_fault=0, fault_pc and fault_seen SHALL hold their values.
REQ-020 Back-to-back faulting cycles SHALL each overwrite fault_pc with the current pc.
REQ-021 All combinational outputs SHALL settle within the same cycle that pc or ibus_rd_data changes, with no clock dependency.

Reset
REQ-022 While rst is high, fault_pc SHALL be 0, fault_seen SHALL be 0 and ibus_rd_en SHALL be 0, asynchronously.
REQ-023 While rst is high, ibus_rd_addr, inst and access_fault SHALL continue to follow pc and ibus_rd_data combinationally.
REQ-024 If rst is asserted mid-operation, it SHALL clear the registers immediately; a fault present at the release edge SHALL be captured only on the first rising clk edge after rst deasserts.

Structure
REQ-025 WIDTH and ROM_ADDR_WIDTH defaults SHALL come from the shared core package constants, alongside the other bus-width constants.
REQ-026 The block SHALL be a single module with no sub-modules; the range check and capture register are inline.

Verification
REQ-027 pc=0x0000_0ABC, ibus_rd_data=~pc -> ibus_rd_addr=0x2AF, inst=0xFFFF_F543, access_fault=0.
REQ-028 pc=0x0000_1000 -> access_fault=1; after the next clk edge fault_pc=0x0000_1000 and fault_seen=1.
REQ-029 A bench SHALL apply 128 random cycles, each with random pc[11:2] and, on about half the cycles, random upper bits -> every cycle ibus_rd_addr=pc[11:2], inst=~pc and access_fault equals the OR of pc[31:12].
REQ-030 Fault at pc=0x8000_0000, then a legal pc=0x4 -> fault_pc stays 0x8000_0000 and fault_seen stays 1.
REQ-031 Assert rst asynchronously between clock edges after a fault -> fault_pc=0, fault_seen=0 and ibus_rd_en=0 immediately; ibus_rd_en returns to 1 after release.
